// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// Each digit gets a slot of REFRESH_DIV cycles. The first DEAD_CYCLES of every
// slot keep all anodes dark to avoid ghosting. The displayed value is latched
// into shadow registers once per frame, so a frame never shows a mix of old
// and new data. All outputs are registered one cycle behind the scan state.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_VAL = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Active-low hex glyphs, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]    div_cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [4*DIGITS-1:0] sh_val_r;
    logic [DIGITS-1:0]   sh_dp_r;
    logic                sh_lz_r;

    logic                slot_end_s;
    logic                snap_s;
    logic                keep_s;
    logic                hit_s;
    logic [3:0]          nib_s;
    logic                dp_sel_s;
    logic                supp_s;
    logic [6:0]          seg_nxt_s;
    logic                dp_nxt_s;
    logic [DIGITS-1:0]   an_nxt_s;

    // Slot and frame boundary detection.
    always_comb begin
        slot_end_s = (div_cnt_r == DIV_LAST);
        snap_s     = slot_end_s && (idx_r == IDX_LAST);
    end

    // Select the current digit and decide leading-zero suppression, scanning
    // from the most significant digit down so "anything visible above" is known.
    always_comb begin
        keep_s   = 1'b0;
        hit_s    = 1'b0;
        nib_s    = 4'h0;
        dp_sel_s = 1'b0;
        supp_s   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            keep_s   = keep_s | (sh_val_r[4*i +: 4] != 4'h0) | sh_dp_r[i];
            hit_s    = (idx_r == IDX_W'(i));
            nib_s    = hit_s ? sh_val_r[4*i +: 4] : nib_s;
            dp_sel_s = hit_s ? sh_dp_r[i] : dp_sel_s;
            supp_s   = hit_s ? (sh_lz_r & ~keep_s & (i != 0)) : supp_s;
        end
    end

    // Next values of the registered pin outputs.
    always_comb begin
        seg_nxt_s = supp_s ? 7'h7F : hex_to_seg_n(nib_s);
        dp_nxt_s  = supp_s ? 1'b1 : ~dp_sel_s;
        an_nxt_s  = {DIGITS{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            an_nxt_s[i] = ~(enable && (div_cnt_r >= DEAD_VAL) && (idx_r == IDX_W'(i)));
        end
    end

    // Slot divider, digit index and once-per-frame input snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= '0;
            idx_r     <= '0;
            sh_val_r  <= '0;
            sh_dp_r   <= '0;
            sh_lz_r   <= 1'b0;
        end else begin
            if (slot_end_s) begin
                div_cnt_r <= '0;
                idx_r     <= (idx_r == IDX_LAST) ? IDX_W'(0) : idx_r + IDX_W'(1);
            end else begin
                div_cnt_r <= div_cnt_r + CNT_W'(1);
                idx_r     <= idx_r;
            end
            if (snap_s) begin
                sh_val_r <= value;
                sh_dp_r  <= dp_in;
                sh_lz_r  <= blank_lz;
            end else begin
                sh_val_r <= sh_val_r;
                sh_dp_r  <= sh_dp_r;
                sh_lz_r  <= sh_lz_r;
            end
        end
    end

    // Output registers: pins lag the scan state by exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            an_n        <= {DIGITS{1'b1}};
            frame_start <= 1'b0;
        end else begin
            seg_n       <= seg_nxt_s;
            dp_n        <= dp_nxt_s;
            an_n        <= an_nxt_s;
            frame_start <= snap_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=8,
// DEAD_CYCLES=2). Every sampled cycle of a frame is compared against a
// hand-computed expectation of anodes, segments, decimal point and frame_start.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int RDIV   = 8;
    localparam int DEAD   = 2;

    logic                clk;
    logic                reset;
    logic [15:0]         value;
    logic [3:0]          dp_in;
    logic                blank_lz;
    logic                enable;
    logic [6:0]          seg_n;
    logic                dp_n;
    logic [3:0]          an_n;
    logic                frame_start;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        lz;
        logic        en;
        logic [27:0] segs;   // expected seg_n per digit, digit 0 in [6:0]
        logic [3:0]  dps;    // expected dp_n per digit
    } vec_t;

    vec_t vecs[10];

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .enable      (enable),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sampled cycle of a frame: outputs reflect slot s, divider count k.
    task automatic check_cycle(input int s, input int k, input logic [27:0] segs,
                               input logic [3:0] dps, input string tag);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fs;
        @(posedge clk);
        #1;
        e_an = 4'hF;
        if (enable && k >= DEAD) e_an[s] = 1'b0;
        e_seg = segs[7*s +: 7];
        e_dp  = dps[s];
        e_fs  = (s == 3 && k == 7);
        checks++;
        if ({an_n, seg_n, dp_n, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            failures++;
            $display("FAIL %s slot=%0d cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                     tag, s, k, an_n, seg_n, dp_n, frame_start, e_an, e_seg, e_dp, e_fs);
        end
    endtask

    task automatic scan_frame(input logic [27:0] segs, input logic [3:0] dps, input string tag);
        for (int n = 0; n < DIGITS * RDIV; n++) check_cycle(n / RDIV, n % RDIV, segs, dps, tag);
    endtask

    // Advance to the next frame_start pulse, bounded.
    task automatic wait_frame(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (frame_start === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s frame_start not seen within 100 cycles", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({an_n, seg_n, dp_n, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL %s got an=%b seg=%h dp=%b fs=%b want an=1111 seg=7f dp=1 fs=0",
                     tag, an_n, seg_n, dp_n, frame_start);
        end
    endtask

    initial begin
        vecs[0] = '{16'h1A3F, 4'b0000, 1'b0, 1'b1, {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1111};
        vecs[1] = '{16'h0040, 4'b0000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0040, 4'b0100, 1'b1, 1'b1, {7'h7F, 7'h40, 7'h19, 7'h40}, 4'b1011};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
        vecs[5] = '{16'h8C0D, 4'b0001, 1'b1, 1'b1, {7'h00, 7'h46, 7'h40, 7'h21}, 4'b1110};
        vecs[6] = '{16'h1234, 4'b0000, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[7] = '{16'h0070, 4'b1000, 1'b1, 1'b1, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b0111};
        vecs[8] = '{16'hB6E5, 4'b0000, 1'b0, 1'b1, {7'h03, 7'h02, 7'h06, 7'h12}, 4'b1111};
        vecs[9] = '{16'h0009, 4'b0010, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h40, 7'h10}, 4'b1101};

        reset    = 1'b1;
        value    = 16'h0000;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        enable   = 1'b1;

        // Reset held for 20 cycles: everything dark.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset_hold");
        end
        reset = 1'b0;

        // First frame after release: all digits "0", frame_start at cycle 32.
        scan_frame({4{7'h40}}, 4'b1111, "first_frame");

        // Table-driven vectors: each applied before a snapshot, then one frame checked.
        for (int v = 0; v < 10; v++) begin
            value    = vecs[v].val;
            dp_in    = vecs[v].dp;
            blank_lz = vecs[v].lz;
            enable   = vecs[v].en;
            wait_frame("vec_sync");
            scan_frame(vecs[v].segs, vecs[v].dps, $sformatf("vec%0d", v));
        end

        // Mid-frame value change is held off until the next frame.
        value    = 16'h1111;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        enable   = 1'b1;
        wait_frame("chg_sync");
        for (int n = 0; n < DIGITS * RDIV; n++) begin
            check_cycle(n / RDIV, n % RDIV, {4{7'h79}}, 4'b1111, "chg_old");
            if (n == 20) value = 16'h2222;
        end
        scan_frame({4{7'h24}}, 4'b1111, "chg_new");

        // enable toggled mid-slot; frame_start must still land on cycle 32.
        for (int n = 0; n < DIGITS * RDIV; n++) begin
            check_cycle(n / RDIV, n % RDIV, {4{7'h24}}, 4'b1111, "enable_toggle");
            if (n == 10) enable = 1'b0;
            if (n == 13) enable = 1'b1;
        end

        // One-cycle reset in the middle of slot 2.
        for (int n = 0; n < 20; n++) check_cycle(n / RDIV, n % RDIV, {4{7'h24}}, 4'b1111, "pre_reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        scan_frame({4{7'h40}}, 4'b1111, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
